// File: rtl/ludh_ctrl_pkg.sv
// Shared definitions for the LUD control-word player: FSM encodings and default sizes.
package ludh_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_CTRL_WIDTH = 307;
    localparam int unsigned DEF_CNT_WIDTH  = 32;
    localparam int unsigned STATE_WIDTH    = 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_OVR  = 2'b11;

endpackage

// File: rtl/ctrl_word_ram.sv
// True dual-port control-word RAM with registered reads.
// Port A belongs to the host (read/write); port B is the sequencer's read-only port.
module ctrl_word_ram
    import ludh_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_a_en,
    input  logic                  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_din,
    output logic [DATA_WIDTH-1:0] o_a_dout,
    input  logic                  i_b_en,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    output logic [DATA_WIDTH-1:0] o_b_dout
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_a_dout;
    logic [DATA_WIDTH-1:0] r_b_dout;

    // Host port: read-before-write on a shared address.
    always_ff @(posedge i_clk) begin
        if (i_a_en) begin
            if (i_a_we) begin
                r_mem[i_a_addr] <= i_a_din;
            end
            r_a_dout <= r_mem[i_a_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_b_en) begin
            r_b_dout <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_dout;
    assign o_b_dout = r_b_dout;

endmodule

// File: rtl/ludh_ctrl_player.sv
// Control-word player: streams RAM words onto the LUD control bus while START is high,
// stopping on the done bit or flagging an overrun at the latched end address.
module ludh_ctrl_player
    import ludh_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int unsigned DONE_BIT   = 0,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                   i_clk_100,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_step_mode,
    input  logic                   i_step,
    input  logic [ADDR_WIDTH-1:0]  i_end_addr,
    input  logic [ADDR_WIDTH-1:0]  i_host_addr,
    input  logic [CTRL_WIDTH-1:0]  i_host_din,
    output logic [CTRL_WIDTH-1:0]  o_host_dout,
    input  logic                   i_host_en,
    input  logic                   i_host_we,
    output logic [CTRL_WIDTH-1:0]  o_ctrl_signal,
    output logic                   o_completed,
    output logic                   o_overrun,
    output logic [CNT_WIDTH-1:0]   o_cycle_count,
    output logic [STATE_WIDTH-1:0] o_debug_state
);

    logic [STATE_WIDTH-1:0] r_state;
    logic [STATE_WIDTH-1:0] w_state_nxt;
    logic                   r_completed;
    logic                   r_overrun;
    logic                   w_completed_nxt;
    logic                   w_overrun_nxt;

    logic [ADDR_WIDTH-1:0]  r_seq_addr;
    logic [ADDR_WIDTH-1:0]  r_end_addr;
    logic                   r_valid_q;
    logic                   r_q_last;
    logic                   r_end_issued;
    logic [CNT_WIDTH-1:0]   r_cycle_count;

    logic [CTRL_WIDTH-1:0]  w_ram_q;
    logic                   w_run;
    logic                   w_drive;
    logic                   w_issue;
    logic                   w_at_end;
    logic                   w_launch;
    logic                   w_host_we;

    assign w_run     = (r_state == ST_RUN);
    assign w_drive   = i_start && w_run && r_valid_q;
    assign w_issue   = i_start && w_run && !r_end_issued && (i_step_mode ? i_step : 1'b1);
    assign w_at_end  = (r_seq_addr == r_end_addr);
    assign w_launch  = (r_state == ST_IDLE) && i_start;
    assign w_host_we = i_host_we && (r_state == ST_IDLE);

    ctrl_word_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (CTRL_WIDTH)
    ) u_ram (
        .i_clk    (i_clk_100),
        .i_a_en   (i_host_en),
        .i_a_we   (w_host_we),
        .i_a_addr (i_host_addr),
        .i_a_din  (i_host_din),
        .o_a_dout (o_host_dout),
        .i_b_en   (w_issue),
        .i_b_addr (r_seq_addr),
        .o_b_dout (w_ram_q)
    );

    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_completed <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_completed <= w_completed_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next state; a driven word decides DONE vs OVR, START low always wins.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_start) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_drive) begin
                        if (w_ram_q[DONE_BIT]) begin
                            w_state_nxt = ST_DONE;
                        end else if (r_q_last) begin
                            w_state_nxt = ST_OVR;
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
        w_completed_nxt = (w_state_nxt != ST_RUN);
        w_overrun_nxt   = (w_state_nxt == ST_OVR);
    end

    // Sequencer address/valid tracking; the end flag stops reads without wrapping.
    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq_addr   <= '0;
            r_end_addr   <= '0;
            r_valid_q    <= 1'b0;
            r_q_last     <= 1'b0;
            r_end_issued <= 1'b0;
        end else begin
            if (w_launch) begin
                r_end_addr <= i_end_addr;
            end
            if (!w_run) begin
                r_seq_addr   <= '0;
                r_end_issued <= 1'b0;
            end else if (w_issue) begin
                if (w_at_end) begin
                    r_end_issued <= 1'b1;
                end else begin
                    r_seq_addr <= r_seq_addr + ADDR_WIDTH'(1);
                end
            end
            r_valid_q <= w_issue;
            r_q_last  <= w_issue && w_at_end;
        end
    end

    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_count <= '0;
        end else if (w_launch) begin
            r_cycle_count <= '0;
        end else if (w_drive && (r_cycle_count != {CNT_WIDTH{1'b1}})) begin
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
        end
    end

    assign o_ctrl_signal = w_drive ? w_ram_q : '0;
    assign o_completed   = r_completed;
    assign o_overrun     = r_overrun;
    assign o_cycle_count = r_cycle_count;
    assign o_debug_state = r_state;

endmodule
